// File: rtl/axi_slave_mem_backend_if.sv
// Strobe-level bus between pure_AXI_slave_design (master side) and its
// word-addressed memory backend (slave side).
interface axi_slave_mem_backend_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic [AXI_DATA_WIDTH-1:0]   write_data;
    logic [AXI_DATA_WIDTH/8-1:0] write_strb;
    logic [AXI_ADDR_WIDTH-1:0]   w_opt_addr;
    logic                        write_valid;
    logic [AXI_ADDR_WIDTH-1:0]   r_opt_addr;
    logic                        read_req;
    logic [AXI_DATA_WIDTH-1:0]   read_data;
    logic                        read_valid;
    logic                        aw_ar_ready;

    modport master (
        output write_data, write_strb, w_opt_addr, write_valid, r_opt_addr, read_req,
        input  read_data, read_valid, aw_ar_ready
    );

    modport slave (
        input  write_data, write_strb, w_opt_addr, write_valid, r_opt_addr, read_req,
        output read_data, read_valid, aw_ar_ready
    );
endinterface

// File: rtl/axi_slave_mem_backend.sv
// Word-addressed register memory behind the AXI slave front end.
// Writes land on the strobe edge in any state; reads are sampled at the
// accept edge and returned READ_LATENCY cycles later, with aw_ar_ready low
// while a read is in flight.
// Optional feature: define MEM_ERR_CNT_EN to add the saturating err_count
// output (out-of-range accesses and reads ignored while busy).
module axi_slave_mem_backend #(
    parameter int AXI_DATA_WIDTH   = 32,
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int DATA_MEM_LENGTH  = 16,
    parameter int ADDR_LSB         = 2,
    parameter int ADDR_BASE_OFFSET = 0,
    parameter int READ_LATENCY     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef MEM_ERR_CNT_EN
    output logic [15:0]            err_count,
`endif
    axi_slave_mem_backend_if.slave bus
);
    localparam int IDX_W = (DATA_MEM_LENGTH > 1) ? $clog2(DATA_MEM_LENGTH) : 1;
    localparam int CNT_W = 3;
    localparam int NBYTE = AXI_DATA_WIDTH / 8;
    localparam logic [AXI_ADDR_WIDTH-1:0] BASE    = AXI_ADDR_WIDTH'(ADDR_BASE_OFFSET);
    localparam logic [AXI_ADDR_WIDTH-1:0] LEN     = AXI_ADDR_WIDTH'(DATA_MEM_LENGTH);
    localparam logic [CNT_W-1:0]          CNT_LD  = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [0:0] {ST_IDLE, ST_RD_BUSY} state_t;

    // Decoded view of one byte address.
    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } dec_t;

    // Index is formed in full address width so a wrapped subtraction or a
    // large offset can never alias onto a valid word.
    function automatic dec_t f_decode(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] full;
        dec_t d;
        full  = (addr - BASE) >> ADDR_LSB;
        d.hit = (addr >= BASE) && (full < LEN);
        d.idx = full[IDX_W-1:0];
        return d;
    endfunction

    logic [AXI_DATA_WIDTH-1:0] r_mem [DATA_MEM_LENGTH];
    state_t                    r_state, w_next_state;
    logic [CNT_W-1:0]          r_cnt, w_next_cnt;
    logic [AXI_DATA_WIDTH-1:0] r_rd_word;
    logic [AXI_DATA_WIDTH-1:0] r_read_data;
    logic                      r_read_valid;
    logic                      r_aw_ar_ready;

    dec_t                      w_wr_dec, w_rd_dec;
    logic [AXI_DATA_WIDTH-1:0] w_rd_word;
    logic                      w_rd_accept;
    logic                      w_fire;

    assign w_wr_dec    = f_decode(bus.w_opt_addr);
    assign w_rd_dec    = f_decode(bus.r_opt_addr);
    // Old contents: a same-edge write is not visible to this read.
    assign w_rd_word   = w_rd_dec.hit ? r_mem[w_rd_dec.idx] : '0;
    assign w_rd_accept = bus.read_req && (r_state == ST_IDLE);

    assign bus.read_data   = r_read_data;
    assign bus.read_valid  = r_read_valid;
    assign bus.aw_ar_ready = r_aw_ar_ready;

    // Next-state logic; r_cnt holds edges left before the read_valid edge.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_fire       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_accept) begin
                    if (READ_LATENCY == 1) begin
                        w_fire = 1'b1;
                    end else begin
                        w_next_state = ST_RD_BUSY;
                        w_next_cnt   = CNT_LD;
                    end
                end
            end
            ST_RD_BUSY: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_fire       = 1'b1;
                    w_next_state = ST_IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // State, counter and registered ready (tracks state==IDLE).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_aw_ar_ready <= 1'b1;
        end else begin
            r_state       <= w_next_state;
            r_cnt         <= w_next_cnt;
            r_aw_ar_ready <= (w_next_state == ST_IDLE);
        end
    end

    // Read data path: latch at accept, publish on the fire edge, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_word    <= '0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
        end else begin
            if (w_rd_accept) begin
                r_rd_word <= w_rd_word;
            end
            r_read_valid <= w_fire;
            if (w_fire) begin
                r_read_data <= (READ_LATENCY == 1) ? w_rd_word : r_rd_word;
            end
        end
    end

    // Byte-strobed writes, accepted in every state so burst beats drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DATA_MEM_LENGTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.write_valid && w_wr_dec.hit) begin
            for (int b = 0; b < NBYTE; b++) begin
                if (bus.write_strb[b]) begin
                    r_mem[w_wr_dec.idx][8*b +: 8] <= bus.write_data[8*b +: 8];
                end
            end
        end
    end

`ifdef MEM_ERR_CNT_EN
    logic [15:0] r_err_count;
    logic [1:0]  w_err_inc;
    logic [16:0] w_err_sum;

    // A read is either accepted (and maybe out of range) or ignored, never both.
    assign w_err_inc = {1'b0, bus.write_valid && !w_wr_dec.hit}
                     + {1'b0, (w_rd_accept && !w_rd_dec.hit) ||
                              (bus.read_req && (r_state == ST_RD_BUSY))};
    assign w_err_sum = {1'b0, r_err_count} + {15'd0, w_err_inc};
    assign err_count = r_err_count;

    // Saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else begin
            r_err_count <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end
`endif
endmodule
